// File: rtl/tcm_dport_arbiter.sv
// tcm_dport_arbiter: round-robin arbiter sharing one TCM data port between the core (0) and the loader (1)
module tcm_dport_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_wr_i,
    input  logic        m0_rd_i,
    input  logic [3:0]  m0_wr_i,
    input  logic [10:0] m0_req_tag_i,
    output logic        m0_accept_o,
    output logic        m0_ack_o,
    output logic        m0_error_o,
    output logic [31:0] m0_data_rd_o,
    output logic [10:0] m0_resp_tag_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_wr_i,
    input  logic        m1_rd_i,
    input  logic [3:0]  m1_wr_i,
    input  logic [10:0] m1_req_tag_i,
    output logic        m1_accept_o,
    output logic        m1_ack_o,
    output logic        m1_error_o,
    output logic [31:0] m1_data_rd_o,
    output logic [10:0] m1_resp_tag_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_wr_o,
    output logic        s_rd_o,
    output logic [3:0]  s_wr_o,
    output logic [10:0] s_req_tag_o,
    input  logic        s_accept_i,
    input  logic        s_ack_i,
    input  logic        s_error_i,
    input  logic [31:0] s_data_rd_i,
    input  logic [10:0] s_resp_tag_i,
    output logic        spurious_ack_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, HOLD_0, HOLD_1} state_t;

    state_t          state_q, state_d;
    logic            last_q;
    logic [DEPTH-1:0] ids_q;
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;
    logic            spur_q;
    logic            act0, act1, full, empty, gnt_v, gnt_id, xfer, pop, head;

    assign act0  = m0_rd_i | (|m0_wr_i);
    assign act1  = m1_rd_i | (|m1_wr_i);
    assign full  = cnt_q == CNT_FULL;
    assign empty = cnt_q == '0;
    assign xfer  = gnt_v & s_accept_i;
    assign head  = ids_q[rd_q];
    // Responses only pop while out of reset so outputs go quiet the moment rst falls
    assign pop   = rst & s_ack_i & ~empty;

    // Grant selection and FSM next state; a full ID FIFO freezes both
    always_comb begin
        gnt_v   = 1'b0;
        gnt_id  = 1'b0;
        state_d = state_q;
        if (rst && !full) begin
            case (state_q)
                IDLE: begin
                    gnt_v  = act0 | act1;
                    gnt_id = (act0 && act1) ? ~last_q : act1;
                    if (gnt_v && !s_accept_i) state_d = gnt_id ? HOLD_1 : HOLD_0;
                end
                HOLD_0: begin
                    gnt_v  = act0;
                    gnt_id = 1'b0;
                    if (!act0 || s_accept_i) state_d = IDLE;
                end
                HOLD_1: begin
                    gnt_v  = act1;
                    gnt_id = 1'b1;
                    if (!act1 || s_accept_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign m0_accept_o   = xfer & ~gnt_id;
    assign m1_accept_o   = xfer & gnt_id;
    assign s_addr_o      = !gnt_v ? '0 : gnt_id ? m1_addr_i    : m0_addr_i;
    assign s_data_wr_o   = !gnt_v ? '0 : gnt_id ? m1_data_wr_i : m0_data_wr_i;
    assign s_rd_o        = gnt_v & (gnt_id ? m1_rd_i : m0_rd_i);
    assign s_wr_o        = !gnt_v ? '0 : gnt_id ? m1_wr_i      : m0_wr_i;
    assign s_req_tag_o   = !gnt_v ? '0 : gnt_id ? m1_req_tag_i : m0_req_tag_i;

    assign m0_ack_o      = pop & ~head;
    assign m0_error_o    = m0_ack_o & s_error_i;
    assign m0_data_rd_o  = m0_ack_o ? s_data_rd_i : '0;
    assign m0_resp_tag_o = m0_ack_o ? s_resp_tag_i : '0;
    assign m1_ack_o      = pop & head;
    assign m1_error_o    = m1_ack_o & s_error_i;
    assign m1_data_rd_o  = m1_ack_o ? s_data_rd_i : '0;
    assign m1_resp_tag_o = m1_ack_o ? s_resp_tag_i : '0;
    assign spurious_ack_o = spur_q;

    // FSM, round-robin pointer, in-order ID FIFO and sticky spurious-ack flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            ids_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                last_q      <= gnt_id;
                ids_q[wr_q] <= gnt_id;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW + 1)'(xfer) - (AW + 1)'(pop);
            if (s_ack_i && empty) spur_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// tb_tcm_dport_arbiter: directed bench with a queue-based reference model checked every cycle
module tb_tcm_dport_arbiter;
    localparam int DEPTH = 4;

    logic        clk, rst;
    logic [31:0] m0_addr_i, m0_data_wr_i, m1_addr_i, m1_data_wr_i;
    logic        m0_rd_i, m1_rd_i;
    logic [3:0]  m0_wr_i, m1_wr_i;
    logic [10:0] m0_req_tag_i, m1_req_tag_i;
    logic        m0_accept_o, m0_ack_o, m0_error_o, m1_accept_o, m1_ack_o, m1_error_o;
    logic [31:0] m0_data_rd_o, m1_data_rd_o;
    logic [10:0] m0_resp_tag_o, m1_resp_tag_o;
    logic [31:0] s_addr_o, s_data_wr_o;
    logic        s_rd_o;
    logic [3:0]  s_wr_o;
    logic [10:0] s_req_tag_o;
    logic        s_accept_i, s_ack_i, s_error_i;
    logic [31:0] s_data_rd_i;
    logic [10:0] s_resp_tag_i;
    logic        spurious_ack_o;

    int checks = 0;
    int failures = 0;

    tcm_dport_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr_i), .m0_data_wr_i(m0_data_wr_i), .m0_rd_i(m0_rd_i), .m0_wr_i(m0_wr_i),
        .m0_req_tag_i(m0_req_tag_i), .m0_accept_o(m0_accept_o), .m0_ack_o(m0_ack_o),
        .m0_error_o(m0_error_o), .m0_data_rd_o(m0_data_rd_o), .m0_resp_tag_o(m0_resp_tag_o),
        .m1_addr_i(m1_addr_i), .m1_data_wr_i(m1_data_wr_i), .m1_rd_i(m1_rd_i), .m1_wr_i(m1_wr_i),
        .m1_req_tag_i(m1_req_tag_i), .m1_accept_o(m1_accept_o), .m1_ack_o(m1_ack_o),
        .m1_error_o(m1_error_o), .m1_data_rd_o(m1_data_rd_o), .m1_resp_tag_o(m1_resp_tag_o),
        .s_addr_o(s_addr_o), .s_data_wr_o(s_data_wr_o), .s_rd_o(s_rd_o), .s_wr_o(s_wr_o),
        .s_req_tag_o(s_req_tag_o), .s_accept_i(s_accept_i), .s_ack_i(s_ack_i),
        .s_error_i(s_error_i), .s_data_rd_i(s_data_rd_i), .s_resp_tag_i(s_resp_tag_i),
        .spurious_ack_o(spurious_ack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns each outstanding response, who is being held, who won last
    int  q[$];
    int  held = -1;
    int  lastg = 1;
    bit  spur = 0;

    always @(negedge clk) begin
        bit a0, a1;
        int g, h;
        if (!rst) begin
            q.delete();
            held = -1;
            lastg = 1;
            spur = 0;
        end
        a0 = m0_rd_i || (m0_wr_i != 0);
        a1 = m1_rd_i || (m1_wr_i != 0);
        g = -1;
        if (rst && q.size() < DEPTH) begin
            if (held >= 0) g = ((held == 0) ? a0 : a1) ? held : -1;
            else if (a0 && a1) g = 1 - lastg;
            else if (a0) g = 0;
            else if (a1) g = 1;
        end
        h = (rst && s_ack_i && q.size() > 0) ? q[0] : -1;
        chk("m0_accept", m0_accept_o, (g == 0) && s_accept_i);
        chk("m1_accept", m1_accept_o, (g == 1) && s_accept_i);
        chk("s_addr", s_addr_o, g == 0 ? m0_addr_i : g == 1 ? m1_addr_i : 32'h0);
        chk("s_data_wr", s_data_wr_o, g == 0 ? m0_data_wr_i : g == 1 ? m1_data_wr_i : 32'h0);
        chk("s_rd", s_rd_o, g == 0 ? m0_rd_i : g == 1 ? m1_rd_i : 1'b0);
        chk("s_wr", s_wr_o, g == 0 ? m0_wr_i : g == 1 ? m1_wr_i : 4'h0);
        chk("s_req_tag", s_req_tag_o, g == 0 ? m0_req_tag_i : g == 1 ? m1_req_tag_i : 11'h0);
        chk("m0_ack", m0_ack_o, h == 0);
        chk("m0_error", m0_error_o, h == 0 && s_error_i);
        chk("m0_data", m0_data_rd_o, h == 0 ? s_data_rd_i : 32'h0);
        chk("m0_tag", m0_resp_tag_o, h == 0 ? s_resp_tag_i : 11'h0);
        chk("m1_ack", m1_ack_o, h == 1);
        chk("m1_error", m1_error_o, h == 1 && s_error_i);
        chk("m1_data", m1_data_rd_o, h == 1 ? s_data_rd_i : 32'h0);
        chk("m1_tag", m1_resp_tag_o, h == 1 ? s_resp_tag_i : 11'h0);
        chk("spurious", spurious_ack_o, spur);
        if (rst) begin
            if (s_ack_i) begin
                if (q.size() > 0) void'(q.pop_front());
                else spur = 1;
            end
            if (q.size() < DEPTH || g >= 0) begin
                if (held >= 0) begin
                    if (g < 0 || s_accept_i) held = -1;
                end else if (g >= 0 && !s_accept_i) held = g;
            end
            if (g >= 0 && s_accept_i) begin
                q.push_back(g);
                lastg = g;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        m0_addr_i = 0; m0_data_wr_i = 0; m0_rd_i = 0; m0_wr_i = 0; m0_req_tag_i = 0;
        m1_addr_i = 0; m1_data_wr_i = 0; m1_rd_i = 0; m1_wr_i = 0; m1_req_tag_i = 0;
        s_accept_i = 0; s_ack_i = 0; s_error_i = 0; s_data_rd_i = 0; s_resp_tag_i = 0;
    endtask

    initial begin
        rst = 1'b0;
        quiet();
        @(negedge clk);
        chk("reset_accept", m0_accept_o, 0);
        chk("reset_spurious", spurious_ack_o, 0);
        tick();
        rst = 1'b1;
        tick();
        // both read, always accepted: m0 first, then m1; acks return in order
        m0_rd_i = 1; m0_addr_i = 32'h80009000; m0_req_tag_i = 11'h001;
        m1_rd_i = 1; m1_addr_i = 32'h80001000; m1_req_tag_i = 11'h002;
        s_accept_i = 1;
        @(negedge clk);
        chk("rr_first_m0", m0_accept_o, 1);
        chk("rr_first_addr", s_addr_o, 32'h80009000);
        tick();
        m0_rd_i = 0;
        @(negedge clk);
        chk("rr_second_m1", m1_accept_o, 1);
        chk("rr_second_addr", s_addr_o, 32'h80001000);
        tick();
        m1_rd_i = 0; s_accept_i = 0;
        s_ack_i = 1; s_data_rd_i = 32'h11111111; s_resp_tag_i = 11'h001;
        @(negedge clk);
        chk("ack_order_m0", m0_ack_o, 1);
        chk("ack_order_m0_data", m0_data_rd_o, 32'h11111111);
        tick();
        s_data_rd_i = 32'h22222222; s_resp_tag_i = 11'h002;
        @(negedge clk);
        chk("ack_order_m1", m1_ack_o, 1);
        chk("ack_order_m0_quiet", m0_data_rd_o, 0);
        tick();
        quiet();
        // m1 stalled three cycles while m0 also requests
        m1_wr_i = 4'hf; m1_addr_i = 32'h00000100; m1_data_wr_i = 32'hdeadbeef; m1_req_tag_i = 11'h010;
        tick();
        m0_rd_i = 1; m0_addr_i = 32'h00000200; m0_req_tag_i = 11'h020;
        @(negedge clk);
        chk("hold_addr", s_addr_o, 32'h00000100);
        chk("hold_m0_blocked", m0_accept_o, 0);
        tick();
        tick();
        s_accept_i = 1;
        @(negedge clk);
        chk("hold_m1_xfer", m1_accept_o, 1);
        chk("hold_m0_wait", m0_accept_o, 0);
        tick();
        m1_wr_i = 0;
        @(negedge clk);
        chk("after_hold_m0", m0_accept_o, 1);
        tick();
        quiet();
        s_ack_i = 1; s_error_i = 1; s_data_rd_i = 32'h33333333;
        @(negedge clk);
        chk("hold_ack_m1", m1_ack_o, 1);
        chk("hold_err_m1", m1_error_o, 1);
        tick();
        s_error_i = 0;
        @(negedge clk);
        chk("hold_ack_m0", m0_ack_o, 1);
        tick();
        quiet();
        // fill the FIFO: fifth request blocked until the cycle after an ack
        m0_rd_i = 1; m0_addr_i = 32'h00000040; s_accept_i = 1;
        repeat (4) tick();
        @(negedge clk);
        chk("full_no_accept", m0_accept_o, 0);
        chk("full_no_rd", s_rd_o, 0);
        tick();
        s_ack_i = 1;
        @(negedge clk);
        chk("full_ack_cycle", m0_accept_o, 0);
        chk("full_ack_m0", m0_ack_o, 1);
        tick();
        s_ack_i = 0;
        @(negedge clk);
        chk("full_next_cycle", m0_accept_o, 1);
        tick();
        quiet();
        s_ack_i = 1;
        repeat (2) tick();
        // two outstanding: push from m1 and pop of m0 in the same cycle
        m1_rd_i = 1; m1_addr_i = 32'h00000300; s_accept_i = 1;
        s_data_rd_i = 32'hc0de000d; s_resp_tag_i = 11'h005;
        @(negedge clk);
        chk("same_push", m1_accept_o, 1);
        chk("same_head_data", m0_data_rd_o, 32'hc0de000d);
        chk("same_head_tag", m0_resp_tag_o, 11'h005);
        chk("same_other_data", m1_data_rd_o, 0);
        tick();
        m1_rd_i = 0; s_accept_i = 0;
        @(negedge clk);
        chk("drain_m0", m0_ack_o, 1);
        tick();
        @(negedge clk);
        chk("drain_m1", m1_ack_o, 1);
        tick();
        @(negedge clk);
        chk("empty_no_ack0", m0_ack_o, 0);
        chk("empty_no_ack1", m1_ack_o, 0);
        tick();
        s_ack_i = 0;
        repeat (2) tick();
        @(negedge clk);
        chk("spurious_sticky", spurious_ack_o, 1);
        // three outstanding, then asynchronous reset mid-cycle
        tick();
        m0_rd_i = 1; m1_rd_i = 1; s_accept_i = 1;
        repeat (3) tick();
        m1_rd_i = 0; s_ack_i = 1;
        #2 rst = 1'b0;
        #1;
        chk("async_m0_accept", m0_accept_o, 0);
        chk("async_s_rd", s_rd_o, 0);
        chk("async_s_addr", s_addr_o, 0);
        chk("async_m0_ack", m0_ack_o, 0);
        chk("async_spurious", spurious_ack_o, 0);
        tick();
        tick();
        rst = 1'b1; s_ack_i = 0; m1_rd_i = 1;
        @(negedge clk);
        chk("post_reset_m0_wins", m0_accept_o, 1);
        tick();
        m0_rd_i = 0; m1_rd_i = 0; s_accept_i = 0; s_ack_i = 1;
        @(negedge clk);
        chk("post_reset_ack_m0", m0_ack_o, 1);
        tick();
        @(negedge clk);
        chk("post_reset_stale_ack", m0_ack_o | m1_ack_o, 0);
        tick();
        s_ack_i = 0;
        @(negedge clk);
        chk("post_reset_spurious", spurious_ack_o, 1);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
